// File: rtl/core_dispatch_scoreboard.sv
// core_dispatch_scoreboard
// Per-execution-unit in-order FIFOs that track destination registers of
// in-flight instructions and publish pending-write masks to dispatch.
// Optional feature macro: CORE_SCOREBOARD_BYPASS_EN. When it is defined, the
// entry being retired this cycle is removed from the masks combinationally.
// When it is not defined, the masks come purely from registered state.
module core_dispatch_scoreboard #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dispatch_a,
    input  logic        dispatch_b,
    input  logic        wr_a,
    input  logic        wr_b,
    input  logic [3:0]  rd_a,
    input  logic [3:0]  rd_b,
    input  logic [1:0]  eu_a,
    input  logic [1:0]  eu_b,
    input  logic        wb_alu_a,
    input  logic        wb_alu_b,
    input  logic        wb_branch,
    input  logic        wb_ldst,
    output logic [15:0] mask_alu_a,
    output logic [15:0] mask_alu_b,
    output logic [15:0] mask_branch,
    output logic [15:0] mask_ldst,
    output logic [3:0]  eu_full,
    output logic        error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_THR  = CW'(DEPTH - 1);
    localparam int NUM_EU = 4;

    // Entry storage and FIFO bookkeeping, one set per execution unit
    logic [DEPTH-1:0] ent_valid [NUM_EU];
    logic [3:0]       ent_rd    [NUM_EU][DEPTH];
    logic [PW-1:0]    rd_ptr    [NUM_EU];
    logic [PW-1:0]    wr_ptr    [NUM_EU];
    logic [CW-1:0]    count     [NUM_EU];

    // Per-EU decisions for the current cycle
    logic [NUM_EU-1:0] wb_vec;
    logic [NUM_EU-1:0] pop_ok;
    logic [NUM_EU-1:0] underflow;
    logic [NUM_EU-1:0] push_a;
    logic [NUM_EU-1:0] push_b;
    logic [NUM_EU-1:0] acc_a;
    logic [NUM_EU-1:0] acc_b;
    logic [NUM_EU-1:0] dropped;
    logic [CW-1:0]     avail      [NUM_EU];
    logic [CW-1:0]     avail_b    [NUM_EU];
    logic [CW-1:0]     next_count [NUM_EU];
    logic [PW-1:0]     wr_idx_b   [NUM_EU];
    logic [15:0]       mask       [NUM_EU];

    assign wb_vec = {wb_ldst, wb_branch, wb_alu_b, wb_alu_a};

    // Decide pops and pushes per EU: the pop frees a slot first, then slot A
    // (older) and slot B are accepted in order while room remains
    always_comb begin
        for (int e = 0; e < NUM_EU; e++) begin
            pop_ok[e]     = 1'b0;
            underflow[e]  = 1'b0;
            push_a[e]     = 1'b0;
            push_b[e]     = 1'b0;
            acc_a[e]      = 1'b0;
            acc_b[e]      = 1'b0;
            dropped[e]    = 1'b0;
            avail[e]      = '0;
            avail_b[e]    = '0;
            next_count[e] = '0;
            wr_idx_b[e]   = '0;

            pop_ok[e]    = wb_vec[e] && (count[e] != '0);
            underflow[e] = wb_vec[e] && (count[e] == '0);
            push_a[e]    = dispatch_a && wr_a && (eu_a == 2'(e));
            push_b[e]    = dispatch_b && wr_b && (eu_b == 2'(e));

            avail[e]   = count[e] - CW'(pop_ok[e]);
            acc_a[e]   = push_a[e] && (avail[e] < DEPTH_CNT);
            avail_b[e] = avail[e] + CW'(acc_a[e]);
            acc_b[e]   = push_b[e] && (avail_b[e] < DEPTH_CNT);

            dropped[e]    = (push_a[e] && !acc_a[e]) || (push_b[e] && !acc_b[e]);
            next_count[e] = avail_b[e] + CW'(acc_b[e]);
            wr_idx_b[e]   = wr_ptr[e] + PW'(acc_a[e]);
        end
    end

    // FIFO state update: invalidate the retired entry, then write new entries
    // so a push landing on the just-freed slot wins over the invalidation
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NUM_EU; e++) begin
                ent_valid[e] <= '0;
                rd_ptr[e]    <= '0;
                wr_ptr[e]    <= '0;
                count[e]     <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    ent_rd[e][i] <= '0;
                end
            end
        end else begin
            for (int e = 0; e < NUM_EU; e++) begin
                if (pop_ok[e]) begin
                    ent_valid[e][rd_ptr[e]] <= 1'b0;
                    rd_ptr[e]               <= rd_ptr[e] + PW'(1);
                end
                if (acc_a[e]) begin
                    ent_valid[e][wr_ptr[e]] <= 1'b1;
                    ent_rd[e][wr_ptr[e]]    <= rd_a;
                end
                if (acc_b[e]) begin
                    ent_valid[e][wr_idx_b[e]] <= 1'b1;
                    ent_rd[e][wr_idx_b[e]]    <= rd_b;
                end
                wr_ptr[e] <= wr_ptr[e] + PW'(acc_a[e]) + PW'(acc_b[e]);
                count[e]  <= next_count[e];
            end
        end
    end

    // Registered near-full flags (fewer than two free entries) and the sticky
    // protocol error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            eu_full <= '0;
            error   <= 1'b0;
        end else begin
            for (int e = 0; e < NUM_EU; e++) begin
                eu_full[e] <= (next_count[e] >= FULL_THR);
            end
            error <= error || (|underflow) || (|dropped);
        end
    end

    // Pending-write masks: OR of one-hot destinations over valid entries
    always_comb begin
        for (int e = 0; e < NUM_EU; e++) begin
            mask[e] = '0;
            for (int i = 0; i < DEPTH; i++) begin
`ifdef CORE_SCOREBOARD_BYPASS_EN
                if (ent_valid[e][i] && !(pop_ok[e] && (rd_ptr[e] == PW'(i)))) begin
                    mask[e] = mask[e] | (16'h0001 << ent_rd[e][i]);
                end
`else
                if (ent_valid[e][i]) begin
                    mask[e] = mask[e] | (16'h0001 << ent_rd[e][i]);
                end
`endif
            end
        end
    end

    assign mask_alu_a  = mask[0];
    assign mask_alu_b  = mask[1];
    assign mask_branch = mask[2];
    assign mask_ldst   = mask[3];

endmodule
